// File: rtl/mem_pkg.sv
// mem_pkg: shared constants and elaboration helpers for the aspect-ratio RAM model.
//   RDW_READ_FIRST / RDW_WRITE_FIRST : read-during-write mode selectors
//   clog2()       : ceiling log2 used to size the wide-side address
//   ratio_legal() : true when max(a,b)/min(a,b) is exactly 1, 2, 4 or 8
package mem_pkg;

  localparam int RDW_READ_FIRST  = 0;
  localparam int RDW_WRITE_FIRST = 1;

  // Ceiling log2; returns 0 for inputs of 0 or 1.
  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((32'sd1 << i) < v) begin
        r = i + 1;
      end
    end
    return r;
  endfunction

  // Width pair is legal when the larger is 1x, 2x, 4x or 8x the smaller.
  function automatic logic ratio_legal(input int a, input int b);
    int hi;
    int lo;
    int r;
    if (a <= 0 || b <= 0) begin
      return 1'b0;
    end
    hi = (a > b) ? a : b;
    lo = (a > b) ? b : a;
    if ((hi % lo) != 0) begin
      return 1'b0;
    end
    r = hi / lo;
    return (r == 1) || (r == 2) || (r == 4) || (r == 8);
  endfunction

endpackage

// File: rtl/mem_rd_stage.sv
// mem_rd_stage: one read-pipeline register (data + valid) for mem_aspect_sync.
//   clk_i   : clock, rising edge
//   rst_ni  : asynchronous active-low clear of data and valid
//   ld_i    : load strobe; data captured when high, held otherwise
//   d_i     : data to capture
//   q_o     : registered data
//   valid_o : high for exactly one cycle after each load
module mem_rd_stage
  import mem_pkg::*;
#(
  parameter int W = 18
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         ld_i,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] q_o,
  output logic         valid_o
);

  logic [W-1:0] data_q;
  logic [W-1:0] data_d;
  logic         valid_q;
  logic         valid_d;

  // Next state: data holds between loads so q stays stable after the valid pulse.
  always_comb begin
    data_d  = ld_i ? d_i : data_q;
    valid_d = ld_i;
  end

  // Stage registers, cleared asynchronously so in-flight reads are dropped.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      data_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      data_q  <= data_d;
      valid_q <= valid_d;
    end
  end

  assign q_o     = data_q;
  assign valid_o = valid_q;

endmodule

// File: rtl/mem_aspect_sync.sv
// mem_aspect_sync: simple-dual-port RAM model with independent write/read widths.
//   wclk_int  : clock, all state on rising edge
//   rst_int   : asynchronous active-low reset of the read path only
//   we/waddr/wdata : write port, waddr in write-width words
//   re/raddr       : read port, raddr in read-width words
//   q / q_valid    : read data and its strobe, PIPE cycles after re
//   collision      : one-cycle flag after an edge with overlapping write and read
// Storage is 2**NAW narrow words packed little-endian inside each wide word.
module mem_aspect_sync
  import mem_pkg::*;
#(
  parameter  int WW       = 18,
  parameter  int RW       = 18,
  parameter  int NAW      = 10,
  parameter  int PIPE     = 1,
  parameter  int RDW_MODE = 0,
  localparam int NW       = (WW < RW) ? WW : RW,
  localparam int WR       = WW / NW,
  localparam int RR       = RW / NW,
  localparam int LWR      = clog2(WR),
  localparam int LRR      = clog2(RR),
  localparam int WAW      = NAW - LWR,
  localparam int RAW      = NAW - LRR
) (
  input  logic           wclk_int,
  input  logic           rst_int,
  input  logic           we,
  input  logic [WAW-1:0] waddr,
  input  logic [WW-1:0]  wdata,
  input  logic           re,
  input  logic [RAW-1:0] raddr,
  output logic [RW-1:0]  q,
  output logic           q_valid,
  output logic           collision
);

  localparam int DEPTH = 2 ** NAW;

  if (!ratio_legal(WW, RW)) begin : g_bad_ratio
    $error("mem_aspect_sync: max(WW,RW)/min(WW,RW) must be 1, 2, 4 or 8");
  end
  if (PIPE < 0 || PIPE > 2) begin : g_bad_pipe
    $error("mem_aspect_sync: PIPE must be 0, 1 or 2");
  end

  // Only a clean 1 counts as an enable; X or Z is treated as idle.
  logic we_s;
  logic re_s;
  assign we_s = (we === 1'b1);
  assign re_s = (re === 1'b1);

  logic [NW-1:0]  mem_q [DEPTH];
  logic [NAW-1:0] wbase_s;
  logic [NAW-1:0] rbase_s;
  logic [NW-1:0]  wword_s [WR];

  // Wide addresses scaled to the first narrow word they cover.
  assign wbase_s = NAW'(waddr) << LWR;
  assign rbase_s = NAW'(raddr) << LRR;

  for (genvar k = 0; k < WR; k++) begin : g_wword
    assign wword_s[k] = wdata[k*NW +: NW];
  end

  // Storage array: deliberately not reset so contents survive rst_int.
  always_ff @(posedge wclk_int) begin
    if (we_s) begin
      for (int k = 0; k < WR; k++) begin
        mem_q[wbase_s + NAW'(k)] <= wword_s[k];
      end
    end
  end

  // Per narrow read word: pre-write contents, optional bypass, overlap detect.
  logic [RW-1:0] rd_sel_s;
  logic [RR-1:0] hit_vec_s;

  for (genvar j = 0; j < RR; j++) begin : g_rd
    logic [NAW-1:0] naddr_s;
    logic [NW-1:0]  old_s;

    assign naddr_s      = rbase_s + NAW'(j);
    assign old_s        = mem_q[naddr_s];
    // The narrow word belongs to the wide write word naddr >> LWR.
    assign hit_vec_s[j] = we_s && ((naddr_s >> LWR) == NAW'(waddr));

    // PIPE=0 always shows current (pre-edge) contents, so bypass only when registered.
    if (RDW_MODE == RDW_WRITE_FIRST && PIPE != 0) begin : g_wf
      logic [NW-1:0] new_s;
      if (WR == 1) begin : g_w1
        assign new_s = wword_s[0];
      end else begin : g_wn
        assign new_s = wword_s[naddr_s[LWR-1:0]];
      end
      assign rd_sel_s[j*NW +: NW] = hit_vec_s[j] ? new_s : old_s;
    end else begin : g_rf
      assign rd_sel_s[j*NW +: NW] = old_s;
    end
  end

  // Collision is independent of RDW_MODE and PIPE.
  logic coll_d;
  logic coll_q;
  assign coll_d = re_s & (|hit_vec_s);

  // Collision flag register, cleared with the read path.
  always_ff @(posedge wclk_int or negedge rst_int) begin
    if (!rst_int) begin
      coll_q <= 1'b0;
    end else begin
      coll_q <= coll_d;
    end
  end

  assign collision = coll_q;

  // Read pipeline: element 0 is the combinational read, each stage adds one cycle.
  logic [RW-1:0] st_data_s [PIPE+1];
  logic          st_vld_s  [PIPE+1];

  assign st_data_s[0] = rd_sel_s;
  assign st_vld_s[0]  = re_s;

  for (genvar s = 0; s < PIPE; s++) begin : g_pipe
    mem_rd_stage #(
      .W(RW)
    ) u_stage (
      .clk_i  (wclk_int),
      .rst_ni (rst_int),
      .ld_i   (st_vld_s[s]),
      .d_i    (st_data_s[s]),
      .q_o    (st_data_s[s+1]),
      .valid_o(st_vld_s[s+1])
    );
  end

  assign q       = st_data_s[PIPE];
  assign q_valid = st_vld_s[PIPE];

endmodule

// File: tb/tb_mem_aspect_sync.sv
// tb_mem_aspect_sync: directed checks of mem_aspect_sync across several configurations
// plus a PIPE=0 model comparison for every width ratio in both directions.
module tb_mem_aspect_sync;

  int tests_run    = 0;
  int tests_failed = 0;

  logic clk = 1'b0;
  logic rst_n;
  logic b_rst_n;

  always #5 clk = ~clk;

  // Instance A: 32-bit write, 8-bit read, PIPE=1, READ_FIRST
  logic        a_we;
  logic [7:0]  a_waddr;
  logic [31:0] a_wdata;
  logic        a_re;
  logic [9:0]  a_raddr;
  logic [7:0]  a_q;
  logic        a_qv;
  logic        a_col;

  mem_aspect_sync #(.WW(32), .RW(8), .NAW(10), .PIPE(1), .RDW_MODE(0)) u_a (
    .wclk_int(clk), .rst_int(rst_n), .we(a_we), .waddr(a_waddr), .wdata(a_wdata),
    .re(a_re), .raddr(a_raddr), .q(a_q), .q_valid(a_qv), .collision(a_col)
  );

  // Instance B: 8-bit write, 32-bit read, PIPE=2, own reset
  logic        b_we;
  logic [9:0]  b_waddr;
  logic [7:0]  b_wdata;
  logic        b_re;
  logic [7:0]  b_raddr;
  logic [31:0] b_q;
  logic        b_qv;
  logic        b_col;

  mem_aspect_sync #(.WW(8), .RW(32), .NAW(10), .PIPE(2), .RDW_MODE(0)) u_b (
    .wclk_int(clk), .rst_int(b_rst_n), .we(b_we), .waddr(b_waddr), .wdata(b_wdata),
    .re(b_re), .raddr(b_raddr), .q(b_q), .q_valid(b_qv), .collision(b_col)
  );

  // Instances C0/C1: 18-bit both sides, PIPE=1, READ_FIRST vs WRITE_FIRST, shared inputs
  logic        c_we;
  logic [9:0]  c_waddr;
  logic [17:0] c_wdata;
  logic        c_re;
  logic [9:0]  c_raddr;
  logic [17:0] c0_q;
  logic        c0_qv;
  logic        c0_col;
  logic [17:0] c1_q;
  logic        c1_qv;
  logic        c1_col;

  mem_aspect_sync #(.WW(18), .RW(18), .NAW(10), .PIPE(1), .RDW_MODE(0)) u_c0 (
    .wclk_int(clk), .rst_int(rst_n), .we(c_we), .waddr(c_waddr), .wdata(c_wdata),
    .re(c_re), .raddr(c_raddr), .q(c0_q), .q_valid(c0_qv), .collision(c0_col)
  );

  mem_aspect_sync #(.WW(18), .RW(18), .NAW(10), .PIPE(1), .RDW_MODE(1)) u_c1 (
    .wclk_int(clk), .rst_int(rst_n), .we(c_we), .waddr(c_waddr), .wdata(c_wdata),
    .re(c_re), .raddr(c_raddr), .q(c1_q), .q_valid(c1_qv), .collision(c1_col)
  );

  // PIPE=0 configurations: ratios 1, 2 up, 2 down, 4 up, 4 down, 8 up, 8 down
  localparam int NCFG  = 7;
  localparam int R_NAW = 5;
  localparam int CFG_WW [NCFG] = '{8, 8, 16, 4, 16, 4, 32};
  localparam int CFG_RW [NCFG] = '{8, 16, 8, 16, 4, 32, 4};

  function automatic int tb_log2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction

  for (genvar k = 0; k < NCFG; k++) begin : g_rnd
    localparam int GW  = CFG_WW[k];
    localparam int GR  = CFG_RW[k];
    localparam int GN  = (GW < GR) ? GW : GR;
    localparam int GWR = GW / GN;
    localparam int GRR = GR / GN;
    localparam int GWA = R_NAW - tb_log2(GWR);
    localparam int GRA = R_NAW - tb_log2(GRR);

    logic           we;
    logic [GWA-1:0] waddr;
    logic [GW-1:0]  wdata;
    logic           re;
    logic [GRA-1:0] raddr;
    logic [GR-1:0]  q;
    logic           q_valid;
    logic           collision;
    logic [GN-1:0]  model [2**R_NAW];

    mem_aspect_sync #(.WW(GW), .RW(GR), .NAW(R_NAW), .PIPE(0), .RDW_MODE(0)) u_dut (
      .wclk_int(clk), .rst_int(rst_n), .we(we), .waddr(waddr), .wdata(wdata),
      .re(re), .raddr(raddr), .q(q), .q_valid(q_valid), .collision(collision)
    );

    task automatic run_random();
      logic [GR-1:0] exp_q;
      logic          exp_col;
      int            wlo;
      int            rlo;
      we    = 1'b0;
      re    = 1'b0;
      waddr = '0;
      raddr = '0;
      wdata = '0;
      // Preload every location so the model never holds unknowns.
      for (int a = 0; a < 2**GWA; a++) begin
        @(negedge clk);
        we    = 1'b1;
        waddr = GWA'(a);
        wdata = GW'($urandom);
        for (int i = 0; i < GWR; i++) model[a*GWR + i] = wdata[i*GN +: GN];
      end
      @(negedge clk);
      we      = 1'b0;
      exp_col = 1'b0;
      for (int c = 0; c < 2000; c++) begin
        @(negedge clk);
        we    = ($urandom_range(0, 3) != 0);
        re    = ($urandom_range(0, 3) != 0);
        waddr = GWA'($urandom);
        raddr = GRA'($urandom);
        wdata = GW'($urandom);
        #1;
        for (int j = 0; j < GRR; j++) exp_q[j*GN +: GN] = model[int'(raddr)*GRR + j];
        tests_run++;
        if (q !== exp_q || q_valid !== re || collision !== exp_col) begin
          tests_failed++;
          $display("FAIL rnd_ww%0d_rw%0d cycle %0d: q=%h valid=%b coll=%b, expected q=%h valid=%b coll=%b",
                   GW, GR, c, q, q_valid, collision, exp_q, re, exp_col);
        end
        wlo     = int'(waddr) * GWR;
        rlo     = int'(raddr) * GRR;
        exp_col = we && re && (wlo < rlo + GRR) && (rlo < wlo + GWR);
        if (we) begin
          for (int i = 0; i < GWR; i++) model[wlo + i] = wdata[i*GN +: GN];
        end
      end
      @(negedge clk);
      we = 1'b0;
      re = 1'b0;
    endtask
  end

  task automatic test_reset();
    @(negedge clk);
    tests_run++;
    if ({a_q, a_qv, a_col} !== 10'h000) begin
      tests_failed++;
      $display("FAIL reset_a: q=%h valid=%b coll=%b, expected all zero", a_q, a_qv, a_col);
    end
    tests_run++;
    if ({b_q, b_qv, b_col} !== 34'h0) begin
      tests_failed++;
      $display("FAIL reset_b: q=%h valid=%b coll=%b, expected all zero", b_q, b_qv, b_col);
    end
    tests_run++;
    if ({c0_q, c0_qv, c0_col, c1_q, c1_qv, c1_col} !== 40'h0) begin
      tests_failed++;
      $display("FAIL reset_c: c0 q=%h v=%b c=%b c1 q=%h v=%b c=%b, expected all zero",
               c0_q, c0_qv, c0_col, c1_q, c1_qv, c1_col);
    end
    rst_n   = 1'b1;
    b_rst_n = 1'b1;
  endtask

  task automatic test_wide_to_narrow();
    logic [7:0] exp_b [4];
    exp_b[0] = 8'hAA;
    exp_b[1] = 8'hBB;
    exp_b[2] = 8'hCC;
    exp_b[3] = 8'hDD;
    @(negedge clk);
    a_we    = 1'b1;
    a_waddr = 8'd0;
    a_wdata = 32'hDDCCBBAA;
    @(negedge clk);
    a_we = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tests_run++;
      if (i == 0 && a_qv !== 1'b0) begin
        tests_failed++;
        $display("FAIL w2n_idle: valid=%b, expected 0", a_qv);
      end else if (i >= 1 && i <= 4 && (a_qv !== 1'b1 || a_q !== exp_b[i-1])) begin
        tests_failed++;
        $display("FAIL w2n_read%0d: q=%h valid=%b, expected q=%h valid=1", i - 1, a_q, a_qv, exp_b[i-1]);
      end else if (i == 5 && (a_qv !== 1'b0 || a_q !== 8'hDD)) begin
        tests_failed++;
        $display("FAIL w2n_hold: q=%h valid=%b, expected q=dd valid=0", a_q, a_qv);
      end
      a_re    = (i < 4);
      a_raddr = 10'(i);
      @(negedge clk);
    end
  endtask

  task automatic test_partial_collision();
    @(negedge clk);
    a_we    = 1'b1;
    a_waddr = 8'd1;
    a_wdata = 32'h87654321;
    a_re    = 1'b0;
    @(negedge clk);
    a_wdata = 32'h44332211;
    a_re    = 1'b1;
    a_raddr = 10'd6;
    @(negedge clk);
    tests_run++;
    if (a_q !== 8'h65 || a_qv !== 1'b1 || a_col !== 1'b1) begin
      tests_failed++;
      $display("FAIL partial_overlap: q=%h valid=%b coll=%b, expected q=65 valid=1 coll=1", a_q, a_qv, a_col);
    end
    a_raddr = 10'd3;
    @(negedge clk);
    tests_run++;
    if (a_q !== 8'hDD || a_col !== 1'b0) begin
      tests_failed++;
      $display("FAIL adjacent_no_overlap: q=%h coll=%b, expected q=dd coll=0", a_q, a_col);
    end
    a_we    = 1'b0;
    a_raddr = 10'd6;
    @(negedge clk);
    a_re = 1'b0;
    tests_run++;
    if (a_q !== 8'h33 || a_col !== 1'b0) begin
      tests_failed++;
      $display("FAIL partial_after_write: q=%h coll=%b, expected q=33 coll=0", a_q, a_col);
    end
  endtask

  task automatic test_narrow_to_wide();
    logic [7:0] bytes_v [4];
    bytes_v[0] = 8'h11;
    bytes_v[1] = 8'h22;
    bytes_v[2] = 8'h33;
    bytes_v[3] = 8'h44;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      b_we    = 1'b1;
      b_waddr = 10'(4 + i);
      b_wdata = bytes_v[i];
    end
    @(negedge clk);
    b_we    = 1'b0;
    b_re    = 1'b1;
    b_raddr = 8'd1;
    @(negedge clk);
    b_re = 1'b0;
    tests_run++;
    if (b_qv !== 1'b0) begin
      tests_failed++;
      $display("FAIL n2w_early: valid=%b one cycle after re, expected 0", b_qv);
    end
    @(negedge clk);
    tests_run++;
    if (b_qv !== 1'b1 || b_q !== 32'h44332211) begin
      tests_failed++;
      $display("FAIL n2w_read: q=%h valid=%b, expected q=44332211 valid=1", b_q, b_qv);
    end
    @(negedge clk);
    tests_run++;
    if (b_qv !== 1'b0 || b_q !== 32'h44332211) begin
      tests_failed++;
      $display("FAIL n2w_hold: q=%h valid=%b, expected q=44332211 valid=0", b_q, b_qv);
    end
  endtask

  task automatic test_rdw();
    @(negedge clk);
    c_we    = 1'b1;
    c_waddr = 10'd5;
    c_wdata = 18'h000A5;
    c_re    = 1'b0;
    @(negedge clk);
    c_wdata = 18'h0015A;
    c_re    = 1'b1;
    c_raddr = 10'd5;
    @(negedge clk);
    c_we = 1'b0;
    c_re = 1'b0;
    tests_run++;
    if (c0_q !== 18'h000A5 || c0_qv !== 1'b1 || c0_col !== 1'b1) begin
      tests_failed++;
      $display("FAIL rdw_read_first: q=%h valid=%b coll=%b, expected q=000a5 valid=1 coll=1", c0_q, c0_qv, c0_col);
    end
    tests_run++;
    if (c1_q !== 18'h0015A || c1_qv !== 1'b1 || c1_col !== 1'b1) begin
      tests_failed++;
      $display("FAIL rdw_write_first: q=%h valid=%b coll=%b, expected q=0015a valid=1 coll=1", c1_q, c1_qv, c1_col);
    end
    @(negedge clk);
    tests_run++;
    if (c0_col !== 1'b0 || c1_col !== 1'b0 || c0_qv !== 1'b0) begin
      tests_failed++;
      $display("FAIL rdw_coll_clear: coll0=%b coll1=%b valid0=%b, expected 0 0 0", c0_col, c1_col, c0_qv);
    end
    c_re = 1'b1;
    @(negedge clk);
    c_re = 1'b0;
    tests_run++;
    if (c0_q !== 18'h0015A || c1_q !== 18'h0015A) begin
      tests_failed++;
      $display("FAIL rdw_readback: q0=%h q1=%h, expected 0015a 0015a", c0_q, c1_q);
    end
  endtask

  task automatic test_reset_inflight();
    @(negedge clk);
    b_re    = 1'b1;
    b_raddr = 8'd1;
    @(negedge clk);
    b_re = 1'b0;
    #2;
    b_rst_n = 1'b0;
    #1;
    tests_run++;
    if (b_q !== 32'h0 || b_qv !== 1'b0) begin
      tests_failed++;
      $display("FAIL rst_immediate: q=%h valid=%b, expected q=0 valid=0", b_q, b_qv);
    end
    @(negedge clk);
    b_rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      tests_run++;
      if (b_qv !== 1'b0) begin
        tests_failed++;
        $display("FAIL rst_dropped%0d: valid=%b after release, expected 0", i, b_qv);
      end
    end
    b_re = 1'b1;
    @(negedge clk);
    b_re = 1'b0;
    @(negedge clk);
    tests_run++;
    if (b_qv !== 1'b1 || b_q !== 32'h44332211) begin
      tests_failed++;
      $display("FAIL rst_contents_kept: q=%h valid=%b, expected q=44332211 valid=1", b_q, b_qv);
    end
  endtask

  task automatic test_x_enables();
    @(negedge clk);
    c_we    = 1'b1;
    c_waddr = 10'd3;
    c_wdata = 18'h00003;
    @(negedge clk);
    c_we    = 1'bx;
    c_wdata = 18'h3FFFF;
    @(negedge clk);
    c_we    = 1'b0;
    c_re    = 1'b1;
    c_raddr = 10'd3;
    @(negedge clk);
    c_re    = 1'bx;
    c_raddr = 10'd5;
    tests_run++;
    if (c0_q !== 18'h00003 || c0_qv !== 1'b1) begin
      tests_failed++;
      $display("FAIL x_we_ignored: q=%h valid=%b, expected q=00003 valid=1", c0_q, c0_qv);
    end
    @(negedge clk);
    c_re = 1'b0;
    tests_run++;
    if (c0_q !== 18'h00003 || c0_qv !== 1'b0) begin
      tests_failed++;
      $display("FAIL x_re_ignored: q=%h valid=%b, expected q=00003 valid=0", c0_q, c0_qv);
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n   = 1'b0;
    b_rst_n = 1'b0;
    a_we = 1'b0; a_waddr = '0; a_wdata = '0; a_re = 1'b0; a_raddr = '0;
    b_we = 1'b0; b_waddr = '0; b_wdata = '0; b_re = 1'b0; b_raddr = '0;
    c_we = 1'b0; c_waddr = '0; c_wdata = '0; c_re = 1'b0; c_raddr = '0;

    test_reset();
    test_wide_to_narrow();
    test_partial_collision();
    test_narrow_to_wide();
    test_rdw();
    test_reset_inflight();
    test_x_enables();
    g_rnd[0].run_random();
    g_rnd[1].run_random();
    g_rnd[2].run_random();
    g_rnd[3].run_random();
    g_rnd[4].run_random();
    g_rnd[5].run_random();
    g_rnd[6].run_random();

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
